// File: rtl/axi_mm_ring_writer.sv
// axi_mm_ring_writer: buffers an AXI-Stream input in a small FIFO and writes it
// as INCR bursts into a circular memory region over AXI4 write channels.
// Committed-but-unreleased beats are tracked as occupancy; the consumer returns
// space through free_valid/free_beats. flush empties the ring after any burst
// in flight has completed.
// Optional feature macro: AXI_MM_RING_TIMEOUT_EN (idle timeout forces a partial
// burst of whatever the FIFO holds).
module axi_mm_ring_writer #(
    parameter int C_WIDTH     = 64,
    parameter int C_BASE_ADDR = 0,
    parameter int C_MEM_SIZE  = 1048576,
    parameter int C_BURST_LEN = 16,
    parameter int C_TIMEOUT   = 64,
    localparam int BYTES = C_WIDTH / 8,
    localparam int CAP   = C_MEM_SIZE / BYTES,
    localparam int AW    = $clog2(C_BASE_ADDR + C_MEM_SIZE),
    localparam int OW    = $clog2(CAP + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               free_valid,
    input  logic [OW-1:0]      free_beats,
    output logic [OW-1:0]      occupancy,
    output logic [AW-1:0]      wr_addr,
    output logic               error,
    input  logic [C_WIDTH-1:0] s_axis_tdata,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [AW-1:0]      m_axi_awaddr,
    output logic [7:0]         m_axi_awlen,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic [2:0]         m_axi_awsize,
    output logic [1:0]         m_axi_awburst,
    output logic [BYTES-1:0]   m_axi_wstrb,
    output logic [C_WIDTH-1:0] m_axi_wdata,
    output logic               m_axi_wlast,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    input  logic [1:0]         m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready
);
    localparam int DEPTH = 2 * C_BURST_LEN;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BSH   = $clog2(BYTES);
    localparam int SW    = ((OW > CW) ? OW : CW) + 1;
    localparam logic [AW:0] END_ADDR = (AW+1)'(C_BASE_ADDR + C_MEM_SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [C_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wptr, rptr;
    logic [CW-1:0]      count;
    logic [1:0]         state;
    logic               drain, pend, run;
    logic [CW-1:0]      blen, beat;
    logic [AW-1:0]      aw_addr;

    logic               push, pop, commit, w_last_hs, trigger, timeout_hit, flushing;
    logic [AW-1:0]      beat_idx;
    logic [CW-1:0]      to_bound, burst_n;
    logic [SW-1:0]      free_space, occ_sum;
    logic [OW-1:0]      occ_next;
    logic [AW:0]        addr_sum;

    assign s_axis_tready = run && (count != CW'(DEPTH)) && !pend && !flush;
    assign push      = s_axis_tvalid && s_axis_tready;
    assign pop       = (state == ST_DATA) && m_axi_wready;
    assign w_last_hs = pop && m_axi_wlast;
    assign commit    = (state == ST_RESP) && m_axi_bvalid;
    assign flushing  = (state == ST_IDLE) && pend;

    // Base is 4 KiB aligned, so the in-chunk beat offset comes straight from wr_addr.
    assign beat_idx   = wr_addr >> BSH;
    assign to_bound   = CW'(C_BURST_LEN) - CW'(beat_idx & AW'(C_BURST_LEN - 1));
    assign burst_n    = (count < to_bound) ? count : to_bound;
    assign free_space = SW'(CAP) - SW'(occupancy);
    assign trigger    = (state == ST_IDLE) && !pend && (count != '0) &&
                        ((count >= to_bound) || drain) && (free_space >= SW'(burst_n));
    assign addr_sum   = {1'b0, wr_addr} + ((AW+1)'(blen) << BSH);

    assign m_axi_awaddr  = aw_addr;
    assign m_axi_awlen   = 8'(blen - CW'(1));
    assign m_axi_awvalid = (state == ST_ADDR);
    assign m_axi_awsize  = 3'(BSH);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = mem[rptr];
    assign m_axi_wlast   = (beat == blen - CW'(1));
    assign m_axi_wvalid  = (state == ST_DATA);
    assign m_axi_bready  = (state == ST_RESP);

    // Net occupancy: a commit and a release in the same cycle both apply; release saturates at 0.
    always_comb begin
        occ_sum  = SW'(occupancy) + (commit ? SW'(blen) : '0);
        occ_next = OW'(occ_sum);
        if (free_valid) begin
            if (SW'(free_beats) > occ_sum) occ_next = '0;
            else                           occ_next = OW'(occ_sum - SW'(free_beats));
        end
    end

`ifdef AXI_MM_RING_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Idle counter: restarts on every accepted beat, saturates at C_TIMEOUT while data waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              idle_cnt <= '0;
        else if (push || count == '0 || flushing) idle_cnt <= '0;
        else if (idle_cnt != TW'(C_TIMEOUT))     idle_cnt <= idle_cnt + TW'(1);
    end
    assign timeout_hit = (idle_cnt == TW'(C_TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // FIFO storage (data only, never reset).
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= s_axis_tdata;
    end

    // FIFO pointers and fill count; a serviced flush discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flushing) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Burst sequencer: one burst outstanding, AW before W, then wait for B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            blen    <= '0;
            beat    <= '0;
            aw_addr <= AW'(C_BASE_ADDR);
        end else begin
            case (state)
                ST_IDLE: if (trigger) begin
                    blen    <= burst_n;
                    beat    <= '0;
                    aw_addr <= wr_addr;
                    state   <= ST_ADDR;
                end
                ST_ADDR: if (m_axi_awready) state <= ST_DATA;
                ST_DATA: if (pop) begin
                    beat <= beat + CW'(1);
                    if (m_axi_wlast) state <= ST_RESP;
                end
                ST_RESP: if (m_axi_bvalid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ring bookkeeping: commit on B, release from consumer, drain/flush/error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            wr_addr   <= AW'(C_BASE_ADDR);
            occupancy <= '0;
            error     <= 1'b0;
            drain     <= 1'b0;
            pend      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (flushing) begin
                wr_addr   <= AW'(C_BASE_ADDR);
                occupancy <= '0;
                error     <= 1'b0;
                drain     <= 1'b0;
                pend      <= 1'b0;
            end else begin
                if (flush) pend <= 1'b1;
                occupancy <= occ_next;
                if (commit) begin
                    wr_addr <= (addr_sum == END_ADDR) ? AW'(C_BASE_ADDR) : addr_sum[AW-1:0];
                    if (m_axi_bresp != 2'b00) error <= 1'b1;
                end
                if ((push && s_axis_tlast) || timeout_hit) drain <= 1'b1;
                else if (w_last_hs && count == CW'(1) && !push) drain <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_mm_ring_writer.sv
// Directed bench for axi_mm_ring_writer: 64-bit data, 16-beat bursts, 4 KiB ring at 0.
module tb_axi_mm_ring_writer;
    localparam int W = 64, BL = 16, MS = 4096, TO = 32, AW = 12, OW = 10;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, free_valid = 1'b0;
    logic [OW-1:0] free_beats = '0;
    logic [OW-1:0] occupancy;
    logic [AW-1:0] wr_addr, awaddr;
    logic          error;
    logic [W-1:0]  tdata = '0, wdata;
    logic          tlast = 1'b0, tvalid = 1'b0, tready;
    logic [7:0]    awlen;
    logic          awvalid, awready = 1'b1;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic [7:0]    wstrb;
    logic          wlast, wvalid, wready = 1'b1;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0, bready;

    axi_mm_ring_writer #(.C_WIDTH(W), .C_BASE_ADDR(0), .C_MEM_SIZE(MS),
                         .C_BURST_LEN(BL), .C_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .free_valid(free_valid),
        .free_beats(free_beats), .occupancy(occupancy), .wr_addr(wr_addr), .error(error),
        .s_axis_tdata(tdata), .s_axis_tlast(tlast), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_wstrb(wstrb), .m_axi_wdata(wdata),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready));

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int aw_count = 0, b_count = 0, w_count = 0, beat_in_burst = 0, seq = 0;
    int last_awaddr = 0, last_awlen = 0, cur_len = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] pat(input int s);
        return {32'(s), 32'hC0DE_0000 ^ 32'(s * 7)};
    endfunction

    // Bus monitor and write-data scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_count = 0; b_count = 0; w_count = 0; beat_in_burst = 0;
                exp_q.delete();
            end else begin
                if (tvalid && tready) exp_q.push_back(tdata);
                if (awvalid && awready) begin
                    aw_count++; last_awaddr = int'(awaddr); last_awlen = int'(awlen);
                    cur_len = int'(awlen); beat_in_burst = 0;
                end
                if (wvalid && wready) begin
                    beat_in_burst++; w_count++;
                    check("wlast_pos", wlast, beat_in_burst == cur_len + 1);
                    if (exp_q.size() == 0) check("wdata_avail", 0, 1);
                    else check("wdata", wdata, exp_q.pop_front());
                    if (wlast) beat_in_burst = 0;
                end
                if (bvalid && bready) b_count++;
            end
        end
    end

    // Write-response responder: one OKAY/error response per burst.
    initial begin
        bit hs;
        forever begin
            @(posedge clk);
            hs = bvalid && bready;
            #1;
            if (!rst_n || hs) bvalid = 1'b0;
            else if (bready)  bvalid = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; flush = 1'b0; free_valid = 1'b0;
        wready = 1'b1; bresp = 2'b00;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic send_beats(input int n, input bit tl);
        for (int i = 0; i < n; i++) begin
            int  waitc;
            bit  done;
            waitc = 0; done = 1'b0;
            tvalid = 1'b1; tdata = pat(seq); tlast = tl && (i == n - 1);
            while (!done) begin
                @(posedge clk);
                done = tready;
                #1;
                if (!done) begin
                    waitc++;
                    if (waitc > 400) begin
                        checks++;
                        $display("FAIL send_timeout: beat %0d of %0d not accepted, required accept", i, n);
                        tvalid = 1'b0; tlast = 1'b0;
                        return;
                    end
                end
            end
            seq++;
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic wait_aw(input int n);
        int waitc;
        waitc = 0;
        while (aw_count < n && waitc < 200) begin step(1); waitc++; end
        check("aw_seen", aw_count, n);
    endtask

    typedef struct {
        int n; bit tl; int exp_aw; int exp_addr; int exp_len; int exp_occ; int exp_wr;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int  b0, waitc;
        bit  tready_bad;

        vecs[0] = '{16, 1'b0, 1, 0,   15, 16, 128};
        vecs[1] = '{5,  1'b1, 1, 0,   4,  5,  40};
        vecs[2] = '{20, 1'b0, 1, 0,   15, 16, 128};
        vecs[3] = '{3,  1'b1, 1, 0,   2,  3,  24};
        vecs[4] = '{32, 1'b0, 2, 128, 15, 32, 256};
        vecs[5] = '{1,  1'b1, 1, 0,   0,  1,  8};

        // Reset state
        step(2);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_tready", tready, 0);
        check("rst_occ", occupancy, 0);
        check("rst_error", error, 0);
        check("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        step(2);
        check("awsize", awsize, 3);
        check("awburst", awburst, 1);
        check("wstrb", wstrb, 8'hFF);

        // Table-driven single-stream cases
        foreach (vecs[k]) begin
            do_reset();
            send_beats(vecs[k].n, vecs[k].tl);
            step(30);
            check($sformatf("v%0d_aw_count", k), aw_count, vecs[k].exp_aw);
            check($sformatf("v%0d_awaddr", k), last_awaddr, vecs[k].exp_addr);
            check($sformatf("v%0d_awlen", k), last_awlen, vecs[k].exp_len);
            check($sformatf("v%0d_occ", k), occupancy, vecs[k].exp_occ);
            check($sformatf("v%0d_wr_addr", k), wr_addr, vecs[k].exp_wr);
        end

        // tlast burst followed by a boundary-limited burst
        do_reset();
        send_beats(5, 1'b1);
        step(30);
        check("tl_awlen", last_awlen, 4);
        send_beats(16, 1'b0);
        step(30);
        check("bnd_aw_count", aw_count, 2);
        check("bnd_awaddr", last_awaddr, 40);
        check("bnd_awlen", last_awlen, 10);
        check("bnd_occ", occupancy, 16);
        check("bnd_leftover", exp_q.size(), 5);

        // Ring fills without release, then wraps after a release
        do_reset();
        send_beats(528, 1'b0);
        step(30);
        check("full_occ", occupancy, 512);
        check("full_wr_addr", wr_addr, 0);
        check("full_aw_count", aw_count, 32);
        check("full_tready_16", tready, 1);
        send_beats(16, 1'b0);
        step(3);
        check("full_tready_32", tready, 0);
        free_valid = 1'b1; free_beats = 10'd16;
        step(1);
        free_valid = 1'b0;
        step(30);
        check("wrap_aw_count", aw_count, 33);
        check("wrap_awaddr", last_awaddr, 0);
        check("wrap_awlen", last_awlen, 15);
        check("wrap_occ", occupancy, 512);
        free_valid = 1'b1; free_beats = 10'd600;
        step(1);
        free_valid = 1'b0;
        check("release_saturate", occupancy, 0);

        // Flush in the middle of the data phase
        do_reset();
        wready = 1'b0;
        send_beats(16, 1'b0);
        wait_aw(1);
        wready = 1'b1;
        step(4);
        wready = 1'b0;
        check("flush_beats_before", beat_in_burst, 4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_tready_pending", tready, 0);
        wready = 1'b1;
        b0 = b_count; waitc = 0; tready_bad = 1'b0;
        while (b_count == b0 && waitc < 100) begin
            if (tready) tready_bad = 1'b1;
            step(1); waitc++;
        end
        check("flush_resp_seen", b_count, b0 + 1);
        check("flush_tready_low", tready_bad, 0);
        check("flush_w_count", w_count, 16);
        step(3);
        check("flush_occ", occupancy, 0);
        check("flush_wr_addr", wr_addr, 0);
        check("flush_tready_after", tready, 1);

        // Error response is sticky and beats still commit
        do_reset();
        bresp = 2'b10;
        send_beats(16, 1'b0);
        step(30);
        check("err_set", error, 1);
        check("err_occ", occupancy, 16);
        bresp = 2'b00;
        send_beats(16, 1'b0);
        step(30);
        check("err_sticky", error, 1);
        check("err_occ2", occupancy, 32);

        // Reset while a burst is in flight
        do_reset();
        wready = 1'b0;
        send_beats(16, 1'b0);
        wait_aw(1);
        wready = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst_awvalid", awvalid, 0);
        check("midrst_wvalid", wvalid, 0);
        check("midrst_bready", bready, 0);
        check("midrst_tready", tready, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_wr_addr", wr_addr, 0);
        step(2);
        rst_n = 1'b1;
        step(20);
        check("midrst_no_aw", aw_count, 0);
        check("midrst_no_w", w_count, 0);

        // Short packet without tlast
        do_reset();
        send_beats(3, 1'b0);
        step(60);
`ifdef AXI_MM_RING_TIMEOUT_EN
        check("timeout_aw_count", aw_count, 1);
        check("timeout_awlen", last_awlen, 2);
        check("timeout_occ", occupancy, 3);
`else
        check("notimeout_aw_count", aw_count, 0);
        check("notimeout_occ", occupancy, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
